// File: rtl/frame_update_scheduler_pkg.sv
// ---- frame_update_scheduler_pkg : shared states, VGA timing constants, helpers (rev 1.0) ----
`default_nettype none

package frame_update_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // 640x480@60 timing of the upstream VGA generator
  localparam int HPIXELS = 800;
  localparam int VLINES  = 521;
  localparam int HPULSE  = 96;
  localparam int VPULSE  = 2;
  localparam int HBP     = 144;
  localparam int HFP     = 784;
  localparam int VBP     = 31;
  localparam int VFP     = 511;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_update_scheduler_phase_timer.sv
// ---- frame_update_scheduler_phase_timer : loadable down-counter with zero flag (rev 1.0) ----
`default_nettype none

module frame_update_scheduler_phase_timer
  import frame_update_scheduler_pkg::*;
#(
  parameter int TW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/frame_update_scheduler.sv
// ---- frame_update_scheduler : runs the engine phases once per frame from vsync (rev 1.0) ----
`default_nettype none

module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TIMEOUT    = 4096,
  parameter int TW         = 13
) (
  input  logic                  dclk,
  input  logic                  clr,
  input  logic                  vsync,
  input  logic                  pause,
  input  logic                  err_clr,
  input  logic [NUM_PHASES-1:0] done,
  output logic [NUM_PHASES-1:0] start,
  output logic                  frame_tick,
  output logic                  update_done,
  output logic                  busy,
  output logic [2:0]            phase,
  output logic [31:0]           frame_count,
  output logic [NUM_PHASES-1:0] timeout_mask,
  output logic [7:0]            overrun_cnt
);

  localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMEOUT - 1);
  localparam logic [2:0]    LAST_PHASE = 3'(NUM_PHASES - 1);

  state_t                  state;
  logic                    vsync_q;
  logic                    fs;
  logic [NUM_PHASES-1:0]   sel;
  logic                    skip;
  logic                    done_sel;
  logic                    tmr_zero;
  logic                    timed_out;
  logic                    adv;
  logic [NUM_PHASES-1:0]   to_set;

  assign fs        = vsync_q & ~vsync;
  assign sel       = NUM_PHASES'(1) << phase;
  assign skip      = pause & (phase != 3'd0);
  // only the current phase's done bit counts; everything else is ignored
  assign done_sel  = |(done & sel);
  assign timed_out = (state == S_WAIT) && !done_sel && tmr_zero;
  assign adv       = ((state == S_ISSUE) && skip) ||
                     ((state == S_WAIT) && (done_sel || tmr_zero));
  assign to_set    = timed_out ? sel : '0;
  assign start     = ((state == S_ISSUE) && !skip) ? sel : '0;
  assign busy      = (state != S_IDLE);

  frame_update_scheduler_phase_timer #(
    .TW (TW)
  ) u_timer (
    .clk      (dclk),
    .rst      (clr),
    .load     (state == S_ISSUE),
    .en       ((state == S_WAIT) && !done_sel),
    .load_val (TMR_LOAD),
    .zero     (tmr_zero)
  );

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state        <= S_IDLE;
      vsync_q      <= 1'b1;
      phase        <= 3'd0;
      frame_tick   <= 1'b0;
      update_done  <= 1'b0;
      frame_count  <= 32'd0;
      timeout_mask <= '0;
      overrun_cnt  <= 8'd0;
    end else begin
      vsync_q     <= vsync;
      frame_tick  <= 1'b0;
      update_done <= 1'b0;

      // a new timeout or dropped frame in the clearing cycle survives the clear
      timeout_mask <= (err_clr ? '0 : timeout_mask) | to_set;
      if (fs && (state != S_IDLE)) begin
        overrun_cnt <= sat_inc8(overrun_cnt);
      end else if (err_clr) begin
        overrun_cnt <= 8'd0;
      end

      case (state)
        S_IDLE: begin
          if (fs) begin
            state       <= S_ISSUE;
            phase       <= 3'd0;
            frame_tick  <= 1'b1;
            frame_count <= frame_count + 32'd1;
          end
        end
        S_ISSUE: begin
          if (!skip) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
        end
        default: state <= S_IDLE;
      endcase

      if (adv) begin
        if (phase == LAST_PHASE) begin
          state       <= S_IDLE;
          phase       <= 3'd0;
          update_done <= 1'b1;
        end else begin
          state <= S_ISSUE;
          phase <= phase + 3'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
// ---- tb_frame_update_scheduler : directed checks of the per-frame phase sequencer (rev 1.0) ----
`default_nettype none

module tb_frame_update_scheduler;

  localparam int NP  = 4;
  localparam int TO  = 1024;
  localparam int TWB = 11;

  logic          dclk = 1'b0;
  logic          clr;
  logic          vsync;
  logic          pause;
  logic          err_clr;
  logic [NP-1:0] done;
  logic [NP-1:0] start;
  logic          frame_tick;
  logic          update_done;
  logic          busy;
  logic [2:0]    phase;
  logic [31:0]   frame_count;
  logic [NP-1:0] timeout_mask;
  logic [7:0]    overrun_cnt;

  frame_update_scheduler #(
    .NUM_PHASES (NP),
    .TIMEOUT    (TO),
    .TW         (TWB)
  ) dut (
    .dclk         (dclk),
    .clr          (clr),
    .vsync        (vsync),
    .pause        (pause),
    .err_clr      (err_clr),
    .done         (done),
    .start        (start),
    .frame_tick   (frame_tick),
    .update_done  (update_done),
    .busy         (busy),
    .phase        (phase),
    .frame_count  (frame_count),
    .timeout_mask (timeout_mask),
    .overrun_cnt  (overrun_cnt)
  );

  always #20 dclk = ~dclk;

  int cyc = 0;
  always @(posedge dclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // engine model: eng_dly[i]>0 answers with a one-cycle done that many cycles after start, 0 never answers
  int            eng_dly[NP];
  int            cnt[NP]    = '{default: 0};
  logic [NP-1:0] pulse      = '0;
  logic [NP-1:0] force_done = '0;
  assign done = pulse | force_done;

  always @(negedge dclk) begin
    for (int i = 0; i < NP; i++) begin
      pulse[i] = 1'b0;
      if (clr === 1'b1) cnt[i] = 0;
      if (cnt[i] > 0) begin
        cnt[i] = cnt[i] - 1;
        if (cnt[i] == 0) pulse[i] = 1'b1;
      end
      if (start[i] === 1'b1 && eng_dly[i] > 0) cnt[i] = eng_dly[i];
    end
  end

  int st_cyc[NP];
  int st_n[NP];
  int tick_cyc, tick_n, ud_cyc, ud_n;

  always @(negedge dclk) begin
    for (int i = 0; i < NP; i++) begin
      if (start[i] === 1'b1) begin
        if (st_n[i] == 0) st_cyc[i] = cyc;
        st_n[i] = st_n[i] + 1;
      end
    end
    if (frame_tick === 1'b1) begin
      if (tick_n == 0) tick_cyc = cyc;
      tick_n = tick_n + 1;
    end
    if (update_done === 1'b1) begin
      if (ud_n == 0) ud_cyc = cyc;
      ud_n = ud_n + 1;
    end
  end

  task automatic clear_log();
    for (int i = 0; i < NP; i++) begin
      st_cyc[i] = -1;
      st_n[i]   = 0;
    end
    tick_cyc = -1; tick_n = 0;
    ud_cyc   = -1; ud_n   = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge dclk);
      #5;
    end
  endtask

  task automatic launch();
    vsync = 1'b0;
    step(1);
    vsync = 1'b1;
  endtask

  task automatic wait_ud(input int maxc, input string name);
    int k = 0;
    while (ud_n == 0 && k < maxc) begin
      step(1);
      k++;
    end
    if (ud_n == 0) check({name, "_update_done_seen"}, 0, 1);
  endtask

  task automatic wait_start(input int idx, input int maxc, input string name);
    int k = 0;
    while (st_n[idx] == 0 && k < maxc) begin
      step(1);
      k++;
    end
    if (st_n[idx] == 0) check({name, "_start_seen"}, 0, 1);
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    eng_dly[0] = d0; eng_dly[1] = d1; eng_dly[2] = d2; eng_dly[3] = d3;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(1);
  endtask

  // offsets are relative to the frame_tick cycle; -1 means that start never pulses
  typedef struct {
    bit pse;
    int dly;
    int exp_s1;
    int exp_s2;
    int exp_s3;
    int exp_ud;
  } vec_t;

  initial begin : watchdog
    #(40 * 60000);
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   exp_s[NP];
    int   n0;
    logic [31:0] fc0;

    vecs[0] = '{1'b0, 3, 4, 8, 12, 16};
    vecs[1] = '{1'b0, 1, 2, 4, 6, 8};
    vecs[2] = '{1'b0, 5, 6, 12, 18, 24};
    vecs[3] = '{1'b1, 1, -1, -1, -1, 5};
    vecs[4] = '{1'b1, 3, -1, -1, -1, 7};

    clr = 1'b1; vsync = 1'b1; pause = 1'b0; err_clr = 1'b0;
    set_dly(3, 3, 3, 3);
    clear_log();
    step(3);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_phase", phase, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_tick_ud", {frame_tick, update_done}, 0);
    check("rst_err", {timeout_mask, overrun_cnt}, 0);
    clr = 1'b0;
    step(2);

    for (int v = 0; v < 5; v++) begin
      pause = vecs[v].pse;
      set_dly(vecs[v].dly, vecs[v].dly, vecs[v].dly, vecs[v].dly);
      exp_s[0] = 0; exp_s[1] = vecs[v].exp_s1; exp_s[2] = vecs[v].exp_s2; exp_s[3] = vecs[v].exp_s3;
      clear_log();
      fc0 = frame_count;
      n0  = cyc;
      launch();
      wait_ud(200, $sformatf("vec%0d", v));
      step(2);
      check($sformatf("vec%0d_tick_latency", v), tick_cyc - n0, 1);
      check($sformatf("vec%0d_tick_count", v), tick_n, 1);
      for (int i = 0; i < NP; i++) begin
        if (exp_s[i] < 0) check($sformatf("vec%0d_start%0d_count", v, i), st_n[i], 0);
        else check($sformatf("vec%0d_start%0d_offset", v, i), st_cyc[i] - tick_cyc, exp_s[i]);
      end
      check($sformatf("vec%0d_update_done_offset", v), ud_cyc - tick_cyc, vecs[v].exp_ud);
      check($sformatf("vec%0d_update_done_count", v), ud_n, 1);
      check($sformatf("vec%0d_frame_count", v), frame_count, fc0 + 32'd1);
      check($sformatf("vec%0d_idle", v), {busy, phase}, 0);
    end
    pause = 1'b0;

    // engine 2 never answers: full timeout, then the sequence carries on
    set_dly(3, 3, 0, 3);
    clear_log();
    launch();
    wait_ud(1200, "timeout");
    step(2);
    check("timeout_start3_gap", st_cyc[3] - st_cyc[2], TO + 1);
    check("timeout_mask", timeout_mask, 4'b0100);
    check("timeout_ud_after_start3", ud_cyc - st_cyc[3], 4);
    pulse_err_clr();
    check("timeout_err_clr", timeout_mask, 0);

    // done arriving on the last WAIT cycle beats the timeout
    set_dly(3, 3, TO, 3);
    clear_log();
    launch();
    wait_ud(1200, "done_wins");
    step(2);
    check("done_wins_mask", timeout_mask, 0);
    check("done_wins_start3_gap", st_cyc[3] - st_cyc[2], TO + 1);

    // frame starts while engine 1 stalls are dropped and counted, saturating
    set_dly(3, 0, 3, 3);
    clear_log();
    fc0 = frame_count;
    launch();
    wait_start(1, 50, "overrun");
    step(2);
    for (int k = 0; k < 260; k++) begin
      vsync = 1'b0;
      step(1);
      vsync = 1'b1;
      if (k == 0) check("overrun_first", overrun_cnt, 1);
      step(1);
    end
    check("overrun_saturated", overrun_cnt, 255);
    check("overrun_frame_count", frame_count, fc0 + 32'd1);
    check("overrun_no_restart", st_n[0], 1);
    check("overrun_still_busy", {busy, phase}, {1'b1, 3'd1});
    wait_ud(1200, "overrun");
    step(2);
    check("overrun_mask", timeout_mask, 4'b0010);
    pulse_err_clr();
    check("overrun_err_clr", {timeout_mask, overrun_cnt}, 0);

    // frame start in the cycle the last phase completes is still an overrun
    set_dly(1, 1, 1, 1);
    clear_log();
    fc0 = frame_count;
    n0  = cyc;
    launch();
    step(n0 + 8 - cyc);
    vsync = 1'b0;
    step(1);
    vsync = 1'b1;
    step(10);
    check("edge_overrun_cnt", overrun_cnt, 1);
    check("edge_overrun_ticks", tick_n, 1);
    check("edge_overrun_frame_count", frame_count, fc0 + 32'd1);
    check("edge_overrun_ud", ud_cyc - n0, 9);
    pulse_err_clr();

    // pause with engines permanently done
    pause = 1'b1;
    force_done = '1;
    set_dly(0, 0, 0, 0);
    clear_log();
    launch();
    wait_ud(50, "pause_instant");
    step(2);
    check("pause_instant_ud", ud_cyc - tick_cyc, 5);
    check("pause_instant_starts", {st_n[0], st_n[1] + st_n[2] + st_n[3]}, {32'd1, 32'd0});
    pause = 1'b0;
    force_done = '0;

    // clr during phase 1 WAIT
    set_dly(3, 0, 3, 3);
    clear_log();
    launch();
    wait_start(1, 50, "clr");
    step(3);
    check("clr_pre_state", {busy, phase}, {1'b1, 3'd1});
    clr = 1'b1;
    step(1);
    check("clr_state", {busy, phase, start}, 0);
    check("clr_frame_count", frame_count, 0);
    clear_log();
    step(2);
    clr = 1'b0;
    step(20);
    check("clr_quiet", st_n[0] + st_n[1] + st_n[2] + st_n[3] + tick_n + ud_n, 0);
    set_dly(3, 3, 3, 3);
    clear_log();
    n0 = cyc;
    launch();
    wait_ud(200, "clr_restart");
    step(2);
    check("clr_restart_tick", tick_cyc - n0, 1);
    check("clr_restart_start0", st_cyc[0] - tick_cyc, 0);
    check("clr_restart_frame_count", frame_count, 1);
    check("clr_restart_ud", ud_cyc - tick_cyc, 16);

    // done[2] held through phase 0 is ignored until phase 2
    force_done = 4'b0100;
    clear_log();
    launch();
    wait_ud(200, "foreign_done");
    step(2);
    check("foreign_done_phase0", st_cyc[1] - st_cyc[0], 4);
    check("foreign_done_phase2", st_cyc[3] - st_cyc[2], 2);
    check("foreign_done_ud", ud_cyc - st_cyc[3], 4);
    force_done = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
